// File: rtl/ram_latency_model_if.sv
// Request/response channel between a bench-side master and the ram_latency_model memory.
// Parameters must match those given to the attached ram_latency_model instance.
interface ram_latency_model_if #(
  parameter int DATA_W          = 64,
  parameter int ADDR_W          = 32,
  parameter int MAX_OUTSTANDING = 8
);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_wen;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_wmask;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_W-1:0]     resp_rdata;
  logic                  resp_wen;
  logic                  resp_err;
  logic [OUT_W-1:0]      outstanding;

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_wen, resp_err, outstanding
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_wen, resp_err, outstanding
  );
endinterface

// File: rtl/ram_latency_model.sv
// Simulation memory with fixed-latency, in-order responses, response back-pressure and a
// bounded number of outstanding requests. Array contents survive reset.
module ram_latency_model #(
  parameter int DATA_W          = 64,
  parameter int ADDR_W          = 32,
  parameter int WORDS           = 4096,
  parameter int LATENCY         = 4,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                clk,
  input  logic                reset,
  ram_latency_model_if.slave  bus
);
  localparam int STRB_W = DATA_W / 8;
  localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int IDX_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int PTR_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [ADDR_W:0]    WORDS_X  = (ADDR_W + 1)'(WORDS);
  localparam logic [PTR_W-1:0]   PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [OUT_W-1:0]   OUT_MAX  = OUT_W'(MAX_OUTSTANDING);

  typedef struct packed {
    logic              vld;
    logic              wen;
    logic              err;
    logic [DATA_W-1:0] rdata;
  } resp_t;

  logic [DATA_W-1:0] mem_q [WORDS];
  resp_t             pipe_q [LATENCY];
  resp_t             fifo_q [MAX_OUTSTANDING];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OUT_W-1:0]  fifo_cnt_q, fifo_cnt_d, outst_q, outst_d;
  logic              accept_s, in_range_s, push_s, pop_s, pop_fifo_s, fifo_empty_s;
  logic [IDX_W-1:0]  idx_s;
  resp_t             entry_s, tail_s, head_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_LAST) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  // Request side: decode and capture read data from the pre-edge array state.
  always_comb begin
    in_range_s    = ({1'b0, bus.req_addr} < WORDS_X);
    idx_s         = bus.req_addr[IDX_W-1:0];
    accept_s      = bus.req_valid & bus.req_ready;
    entry_s       = '0;
    entry_s.vld   = accept_s;
    entry_s.wen   = bus.req_wen;
    entry_s.err   = ~in_range_s;
    if (accept_s && !bus.req_wen && in_range_s) begin
      entry_s.rdata = mem_q[idx_s];
    end else begin
      entry_s.rdata = '0;
    end
  end

  // Response side: the FIFO is bypassed when empty so the pipeline tail is seen directly.
  always_comb begin
    tail_s       = pipe_q[LATENCY-1];
    fifo_empty_s = (fifo_cnt_q == '0);
    if (fifo_empty_s) begin
      head_s = tail_s;
    end else begin
      head_s = fifo_q[rd_ptr_q];
    end
    pop_s      = head_s.vld & bus.resp_ready;
    pop_fifo_s = ~fifo_empty_s & bus.resp_ready;
    push_s     = tail_s.vld & ~(fifo_empty_s & bus.resp_ready);
    if (push_s) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_fifo_s) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    fifo_cnt_d = fifo_cnt_q + OUT_W'(push_s) - OUT_W'(pop_fifo_s);
    outst_d    = outst_q + OUT_W'(accept_s) - OUT_W'(pop_s);
  end

  // Latency pipeline, FIFO pointers and outstanding counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < LATENCY; k++) begin
        pipe_q[k] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      outst_q    <= '0;
    end else begin
      pipe_q[0] <= entry_s;
      for (int k = 1; k < LATENCY; k++) begin
        pipe_q[k] <= pipe_q[k-1];
      end
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      outst_q    <= outst_d;
    end
  end

  // FIFO storage; validity is tracked by the pointers, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_q[wr_ptr_q] <= tail_s;
    end
  end

  // Byte-masked array write; contents are deliberately kept across reset.
  always_ff @(posedge clk) begin
    if (accept_s && bus.req_wen && in_range_s) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (bus.req_wmask[b]) begin
          mem_q[idx_s][b*8 +: 8] <= bus.req_wdata[b*8 +: 8];
        end
      end
    end
  end

  assign bus.req_ready   = ~reset & (outst_q < OUT_MAX);
  assign bus.resp_valid  = head_s.vld;
  assign bus.resp_rdata  = head_s.vld ? head_s.rdata : '0;
  assign bus.resp_wen    = head_s.vld & head_s.wen;
  assign bus.resp_err    = head_s.vld & head_s.err;
  assign bus.outstanding = outst_q;
endmodule

// File: tb/tb_ram_latency_model.sv
// Self-checking bench for ram_latency_model: table-driven vectors plus hand sequences,
// with a response scoreboard checked by a forked monitor.
module tb_ram_latency_model;
  localparam int WORDS   = 4096;
  localparam int LATENCY = 4;
  localparam int MAXO    = 8;
  localparam int NV      = 16;

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic [63:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic        wen;
    logic        err;
    logic [63:0] rdata;
    int          acc;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t exp_q[$];
  logic [63:0] model [logic [31:0]];
  vec_t tbl [NV];

  ram_latency_model_if #(.DATA_W(64), .ADDR_W(32), .MAX_OUTSTANDING(MAXO)) bus ();

  ram_latency_model #(
    .DATA_W(64), .ADDR_W(32), .WORDS(WORDS), .LATENCY(LATENCY), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] model_exp(input logic wen, input logic [31:0] addr);
    if (wen || addr >= 32'(WORDS) || !model.exists(addr)) return 64'h0;
    else return model[addr];
  endfunction

  task automatic note_accept(input logic wen, input logic [31:0] addr, input logic [63:0] wdata,
                             input logic [7:0] wmask, input logic [63:0] exp_rdata,
                             input logic exp_err);
    exp_t        e;
    logic [63:0] w;
    e.wen = wen; e.err = exp_err; e.rdata = exp_rdata; e.acc = cyc + 1;
    exp_q.push_back(e);
    if (wen && addr < 32'(WORDS)) begin
      w = model.exists(addr) ? model[addr] : 64'h0;
      for (int b = 0; b < 8; b++) if (wmask[b]) w[b*8 +: 8] = wdata[b*8 +: 8];
      model[addr] = w;
    end
  endtask

  task automatic issue(input logic wen, input logic [31:0] addr, input logic [63:0] wdata,
                       input logic [7:0] wmask, input logic [63:0] exp_rdata,
                       input logic exp_err, output int acc);
    int budget;
    bus.req_valid = 1'b1; bus.req_wen = wen; bus.req_addr = addr;
    bus.req_wdata = wdata; bus.req_wmask = wmask;
    budget = 0; acc = -1;
    @(negedge clk);
    while (!bus.req_ready && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (!bus.req_ready) begin
      chk("req_accept_timeout", 64'(bus.req_ready), 64'd1);
      bus.req_valid = 1'b0;
    end else begin
      note_accept(wen, addr, wdata, wmask, exp_rdata, exp_err);
      acc = cyc + 1;
      @(posedge clk); #1;
    end
  endtask

  task automatic mreq(input logic wen, input logic [31:0] addr, input logic [63:0] wdata,
                      input logic [7:0] wmask, output int acc);
    issue(wen, addr, wdata, wmask, model_exp(wen, addr), addr >= 32'(WORDS), acc);
  endtask

  task automatic drain();
    bus.req_valid = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (exp_q.size() == 0 && bus.outstanding == '0) break;
      @(posedge clk); #1;
    end
    chk("drain_queue", 64'(exp_q.size()), 64'd0);
    chk("drain_outstanding", 64'(bus.outstanding), 64'd0);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && bus.resp_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL stale_resp: got response rdata %h err %b, expected none", bus.resp_rdata,
                   bus.resp_err);
        end else begin
          e = exp_q[0];
          chk("resp_rdata", bus.resp_rdata, e.rdata);
          chk("resp_wen", 64'(bus.resp_wen), 64'(e.wen));
          chk("resp_err", 64'(bus.resp_err), 64'(e.err));
          chk("resp_not_early", 64'(cyc >= e.acc + LATENCY - 1), 64'd1);
          if (bus.resp_ready) void'(exp_q.pop_front());
        end
      end
    end
  endtask

  initial begin
    int acc, lat, nacc, nvalid;
    tbl[0]  = '{1'b1, 32'd0,          64'h0F0F0F0F0F0F0F0F, 8'hFF, 64'h0, 1'b0};
    tbl[1]  = '{1'b1, 32'd5,          64'h1122334455667788, 8'hFF, 64'h0, 1'b0};
    tbl[2]  = '{1'b0, 32'd5,          64'h0,                8'h00, 64'h1122334455667788, 1'b0};
    tbl[3]  = '{1'b1, 32'd5,          64'hAAAAAAAAAAAAAAAA, 8'h0F, 64'h0, 1'b0};
    tbl[4]  = '{1'b0, 32'd5,          64'h0,                8'h00, 64'h11223344AAAAAAAA, 1'b0};
    tbl[5]  = '{1'b1, 32'd9,          64'h0123456789ABCDEF, 8'hFF, 64'h0, 1'b0};
    tbl[6]  = '{1'b1, 32'd7,          64'hDEADBEEFCAFEF00D, 8'hFF, 64'h0, 1'b0};
    tbl[7]  = '{1'b1, 32'd4095,       64'hFEEDFACE00000001, 8'hFF, 64'h0, 1'b0};
    tbl[8]  = '{1'b0, 32'd4095,       64'h0,                8'h00, 64'hFEEDFACE00000001, 1'b0};
    tbl[9]  = '{1'b0, 32'd4096,       64'h0,                8'h00, 64'h0, 1'b1};
    tbl[10] = '{1'b1, 32'd4096,       64'h5555555555555555, 8'hFF, 64'h0, 1'b1};
    tbl[11] = '{1'b0, 32'd0,          64'h0,                8'h00, 64'h0F0F0F0F0F0F0F0F, 1'b0};
    tbl[12] = '{1'b0, 32'd5,          64'h0,                8'h00, 64'h11223344AAAAAAAA, 1'b0};
    tbl[13] = '{1'b1, 32'd9,          64'h000000000000AB00, 8'h02, 64'h0, 1'b0};
    tbl[14] = '{1'b0, 32'd9,          64'h0,                8'h00, 64'h0123456789ABABEF, 1'b0};
    tbl[15] = '{1'b0, 32'hFFFFFFFF,   64'h0,                8'h00, 64'h0, 1'b1};

    bus.req_valid = 1'b0; bus.req_wen = 1'b0; bus.req_addr = 32'h0;
    bus.req_wdata = 64'h0; bus.req_wmask = 8'h0; bus.resp_ready = 1'b1;
    reset = 1'b1;
    fork
      monitor();
    join_none

    #3;
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 64'd0);
    chk("rst_resp_wen", 64'(bus.resp_wen), 64'd0);
    chk("rst_resp_err", 64'(bus.resp_err), 64'd0);
    chk("rst_outstanding", 64'(bus.outstanding), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_reset", 64'(bus.req_ready), 64'd1);

    // Table vectors, issued back to back with the response side always ready.
    for (int i = 0; i < NV; i++) begin
      issue(tbl[i].wen, tbl[i].addr, tbl[i].wdata, tbl[i].wmask, tbl[i].exp_rdata,
            tbl[i].exp_err, acc);
    end
    drain();

    // Exact read latency on an idle memory.
    mreq(1'b0, 32'd5, 64'h0, 8'h00, acc);
    bus.req_valid = 1'b0;
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        lat = cyc + 1 - acc;
        break;
      end
    end
    chk("read_latency", 64'(lat), 64'(LATENCY));
    drain();

    // Outstanding cap under response back-pressure.
    for (int i = 0; i < 10; i++) begin
      mreq(1'b1, 32'(i), {32'hC0DE0000 + 32'(i), 32'(i) * 32'h01010101}, 8'hFF, acc);
    end
    drain();
    bus.resp_ready = 1'b0;
    nacc = 0;
    bus.req_valid = 1'b1; bus.req_wen = 1'b0; bus.req_addr = 32'd0; bus.req_wmask = 8'h0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        note_accept(1'b0, bus.req_addr, 64'h0, 8'h0, model_exp(1'b0, bus.req_addr), 1'b0);
        nacc++;
      end
      @(posedge clk); #1;
      bus.req_addr = 32'(nacc);
    end
    @(negedge clk);
    chk("accepted_at_cap", 64'(nacc), 64'(MAXO));
    chk("req_ready_at_cap", 64'(bus.req_ready), 64'd0);
    chk("outstanding_at_cap", 64'(bus.outstanding), 64'(MAXO));
    @(posedge clk); #1;
    bus.resp_ready = 1'b1;
    nvalid = 0;
    for (int c = 0; c < 40 && (nacc < 10 || exp_q.size() != 0); c++) begin
      @(negedge clk);
      if (c < MAXO && bus.resp_valid) nvalid++;
      if (bus.req_valid && bus.req_ready) begin
        note_accept(1'b0, bus.req_addr, 64'h0, 8'h0, model_exp(1'b0, bus.req_addr), 1'b0);
        nacc++;
      end
      @(posedge clk); #1;
      bus.req_addr = 32'(nacc);
      if (nacc == 10) bus.req_valid = 1'b0;
    end
    chk("burst_valid_cycles", 64'(nvalid), 64'(MAXO));
    chk("total_accepted", 64'(nacc), 64'd10);
    drain();

    // Read followed immediately by a write to the same word.
    mreq(1'b0, 32'd7, 64'h0, 8'h00, acc);
    mreq(1'b1, 32'd7, 64'h7777000077770000, 8'hFF, acc);
    mreq(1'b0, 32'd7, 64'h0, 8'h00, acc);
    drain();

    // Reset with three reads in flight, the first already presented.
    mreq(1'b0, 32'd5, 64'h0, 8'h00, acc);
    mreq(1'b0, 32'd7, 64'h0, 8'h00, acc);
    mreq(1'b0, 32'd9, 64'h0, 8'h00, acc);
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_resp_valid", 64'(bus.resp_valid), 64'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("mid_rst_outstanding", 64'(bus.outstanding), 64'd0);
    chk("mid_rst_req_ready", 64'(bus.req_ready), 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("post_rst_outstanding", 64'(bus.outstanding), 64'd0);
    mreq(1'b0, 32'd9, 64'h0, 8'h00, acc);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
